// File: rtl/wb_arbiter_if.sv
// Register-file writeback bus between the result sources and the wb_arbiter.
// The issue/pending scoreboard signals exist only when WB_SCOREBOARD_EN is defined.
interface wb_arbiter_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
);
   logic                     src0_valid;
   logic [ADDRESS_WIDTH-1:0] src0_rd;
   logic [DATA_WIDTH-1:0]    src0_data;

   logic                     src1_valid;
   logic                     src1_ready;
   logic [ADDRESS_WIDTH-1:0] src1_rd;
   logic [DATA_WIDTH-1:0]    src1_data;

   logic                     we;
   logic [ADDRESS_WIDTH-1:0] A3;
   logic [DATA_WIDTH-1:0]    WD;

`ifdef WB_SCOREBOARD_EN
   logic                        issue_valid;
   logic [ADDRESS_WIDTH-1:0]    issue_rd;
   logic [(1<<ADDRESS_WIDTH)-1:0] pending;
`endif

   modport master (
      output src0_valid, src0_rd, src0_data,
      output src1_valid, src1_rd, src1_data,
      input  src1_ready,
      input  we, A3, WD
`ifdef WB_SCOREBOARD_EN
      , output issue_valid, issue_rd
      , input  pending
`endif
   );

   modport slave (
      input  src0_valid, src0_rd, src0_data,
      input  src1_valid, src1_rd, src1_data,
      output src1_ready,
      output we, A3, WD
`ifdef WB_SCOREBOARD_EN
      , input  issue_valid, issue_rd
      , output pending
`endif
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: single-cycle src0 vs. 2-deep FIFO of multicycle src1 results,
// with starvation guard. Define WB_SCOREBOARD_EN to add the pending-register scoreboard.
module wb_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic         clk,
   input  logic         res,
   wb_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [1:0]               count;
   logic                     wr_ptr;
   logic                     rd_ptr;
   logic [ADDRESS_WIDTH-1:0] fifo_rd   [2];
   logic [DATA_WIDTH-1:0]    fifo_data [2];
   logic [SW-1:0]            starve;

   logic                     fifo_ne;
   logic                     force_src1;
   logic                     sel_src0;
   logic                     sel_fifo;
   logic                     push;
   logic                     win;
   logic                     win_we;
   logic [ADDRESS_WIDTH-1:0] win_rd;
   logic [DATA_WIDTH-1:0]    win_data;

   // Ready looks only at the registered count, so a full FIFO that pops stays not-ready.
   assign bus.src1_ready = (count != 2'd2);

   always_comb begin
      fifo_ne    = (count != 2'd0);
      force_src1 = fifo_ne && (starve == STARVE_MAX);
      sel_src0   = bus.src0_valid && !force_src1;
      sel_fifo   = fifo_ne && !sel_src0;
      push       = bus.src1_valid && bus.src1_ready;
      win        = sel_src0 || sel_fifo;
      win_rd     = sel_src0 ? bus.src0_rd   : fifo_rd[rd_ptr];
      win_data   = sel_src0 ? bus.src0_data : fifo_data[rd_ptr];
      win_we     = win && (win_rd != '0);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         count        <= 2'd0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_rd[0]   <= '0;
         fifo_rd[1]   <= '0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         starve       <= '0;
         bus.we       <= 1'b0;
         bus.A3       <= '0;
         bus.WD       <= '0;
      end else begin
         if (push) begin
            fifo_rd[wr_ptr]   <= bus.src1_rd;
            fifo_data[wr_ptr] <= bus.src1_data;
            wr_ptr            <= ~wr_ptr;
         end
         if (sel_fifo) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, sel_fifo};

         // Only src0 beating a waiting FIFO head counts as starvation.
         if (sel_src0 && fifo_ne) begin
            if (starve != STARVE_MAX) begin
               starve <= starve + 1'b1;
            end
         end else begin
            starve <= '0;
         end

         bus.we <= win_we;
         if (win_we) begin
            bus.A3 <= win_rd;
            bus.WD <= win_data;
         end
      end
   end

`ifdef WB_SCOREBOARD_EN
   localparam int NREG = 1 << ADDRESS_WIDTH;
   localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

   logic [NREG-1:0] pend_set;
   logic [NREG-1:0] pend_clr;

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (bus.issue_valid) begin
         pend_set[bus.issue_rd] = 1'b1;
      end
      if (win_we) begin
         pend_clr[win_rd] = 1'b1;
      end
   end

   // Clear lands on the edge that presents the write; a same-edge issue wins.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         bus.pending <= '0;
      end else begin
         bus.pending <= ((bus.pending & ~pend_clr) | pend_set) & R0_MASK;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for arbitration/FIFO behaviour,
// hand sequences for reset and (with WB_SCOREBOARD_EN) the scoreboard.
module tb_wb_arbiter;
   logic clk;
   logic res;
   int   tests;
   int   failed;

   wb_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

   wb_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s0v;
      logic [4:0]  s0rd;
      logic [31:0] s0d;
      logic        s1v;
      logic [4:0]  s1rd;
      logic [31:0] s1d;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        rdy;
   } vec_t;

   localparam int NV = 24;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s0v, input logic [4:0] s0rd, input logic [31:0] s0d,
                        input logic s1v, input logic [4:0] s1rd, input logic [31:0] s1d);
      bus.src0_valid = s0v;
      bus.src0_rd    = s0rd;
      bus.src0_data  = s0d;
      bus.src1_valid = s1v;
      bus.src1_rd    = s1rd;
      bus.src1_data  = s1d;
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] a3,
                          input logic [31:0] wd, input logic rdy);
      chk({tag, ".we"},    {31'd0, bus.we},         {31'd0, we});
      chk({tag, ".A3"},    {27'd0, bus.A3},         {27'd0, a3});
      chk({tag, ".WD"},    bus.WD,                  wd);
      chk({tag, ".ready"}, {31'd0, bus.src1_ready}, {31'd0, rdy});
   endtask

   initial begin
      tests  = 0;
      failed = 0;

      //            s0v s0rd   s0d            s1v s1rd   s1d           we  a3     wd             rdy
      vec[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,        1'b1};
      vec[1]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'h12345678, 1'b1};
      vec[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd5,  32'h12345678, 1'b1};
      vec[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,      1'b0, 5'd5,  32'h12345678, 1'b1};
      // push rd7 into an empty FIFO: cannot win the same cycle
      vec[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hA,      1'b0, 5'd5,  32'h12345678, 1'b1};
      // src0 beats the waiting head four times, then the head is forced through
      vec[5]  = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h33,       1'b1};
      vec[6]  = '{1'b1, 5'd3,  32'h34,       1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h34,       1'b1};
      vec[7]  = '{1'b1, 5'd3,  32'h35,       1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h35,       1'b1};
      vec[8]  = '{1'b1, 5'd3,  32'h36,       1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h36,       1'b1};
      vec[9]  = '{1'b1, 5'd3,  32'h37,       1'b0, 5'd0,  32'h0,      1'b1, 5'd7,  32'hA,        1'b1};
      vec[10] = '{1'b1, 5'd3,  32'h38,       1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h38,       1'b1};
      vec[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd3,  32'h38,       1'b1};
      // three back-to-back src1 offers while src0 holds the port; FIFO fills
      vec[12] = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd10, 32'h100,    1'b1, 5'd1,  32'h11,       1'b1};
      vec[13] = '{1'b1, 5'd2,  32'h12,       1'b1, 5'd11, 32'h101,    1'b1, 5'd2,  32'h12,       1'b0};
      vec[14] = '{1'b1, 5'd3,  32'h13,       1'b1, 5'd12, 32'h102,    1'b1, 5'd3,  32'h13,       1'b0};
      // full FIFO pops but ready stays low that cycle, so rd12 is not taken yet
      vec[15] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h102,    1'b1, 5'd10, 32'h100,      1'b1};
      vec[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h102,    1'b1, 5'd11, 32'h101,      1'b1};
      vec[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b1, 5'd12, 32'h102,      1'b1};
      vec[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd12, 32'h102,      1'b1};
      // rd0 from the FIFO is consumed without a write
      vec[19] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hDEAD,   1'b0, 5'd12, 32'h102,      1'b1};
      vec[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd12, 32'h102,      1'b1};
      vec[21] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,     1'b0, 5'd12, 32'h102,      1'b1};
      vec[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b1, 5'd4,  32'h44,       1'b1};
      vec[23] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd4,  32'h44,       1'b1};

      res = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef WB_SCOREBOARD_EN
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd0;
`endif
      #2;
      chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b1);
      step();
      res = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].s0v, vec[i].s0rd, vec[i].s0d, vec[i].s1v, vec[i].s1rd, vec[i].s1d);
         step();
         chk_out($sformatf("vec%0d", i), vec[i].we, vec[i].a3, vec[i].wd, vec[i].rdy);
      end

      // Fill the FIFO behind src0, then reset asynchronously mid-cycle.
      drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd20, 32'h200);
      step();
      chk_out("fill0", 1'b1, 5'd6, 32'h66, 1'b1);
      drive(1'b1, 5'd6, 32'h67, 1'b1, 5'd21, 32'h201);
      step();
      chk_out("fill1", 1'b1, 5'd6, 32'h67, 1'b0);
      drive(1'b1, 5'd6, 32'h68, 1'b0, 5'd0, 32'h0);
      #3;
      res = 1'b1;
      #1;
      chk_out("rst_async", 1'b0, 5'd0, 32'h0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();
      chk_out("rst_held", 1'b0, 5'd0, 32'h0, 1'b1);
      res = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out($sformatf("post_rst%0d", i), 1'b0, 5'd0, 32'h0, 1'b1);
      end

`ifdef WB_SCOREBOARD_EN
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd9;
      step();
      chk("sb.set", {31'd0, bus.pending[9]}, 32'd1);
      bus.issue_valid = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
      step();
      chk("sb.wait", {31'd0, bus.pending[9]}, 32'd1);
      chk("sb.wait_we", {31'd0, bus.we}, 32'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();
      chk_out("sb.wr", 1'b1, 5'd9, 32'h99, 1'b1);
      chk("sb.clr", {31'd0, bus.pending[9]}, 32'd0);

      bus.issue_valid = 1'b1;
      step();
      chk("sb.set2", {31'd0, bus.pending[9]}, 32'd1);
      bus.issue_valid = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h98);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      bus.issue_valid = 1'b1;
      step();
      chk_out("sb.wr2", 1'b1, 5'd9, 32'h98, 1'b1);
      chk("sb.setclr", {31'd0, bus.pending[9]}, 32'd1);
      bus.issue_rd = 5'd0;
      step();
      bus.issue_valid = 1'b0;
      chk("sb.r0", {31'd0, bus.pending[0]}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
